// File: rtl/random_spawner_if.sv
// Spawn-descriptor handshake between the random spawner and the obstacle manager.
// The producer drives valid and payload; the consumer drives ready.
interface random_spawner_if;
    logic       spawn_valid;
    logic       spawn_ready;
    logic [1:0] spawn_lane;
    logic [3:0] spawn_gap;

    modport master (
        output spawn_valid,
        output spawn_lane,
        output spawn_gap,
        input  spawn_ready
    );

    modport slave (
        input  spawn_valid,
        input  spawn_lane,
        input  spawn_gap,
        output spawn_ready
    );
endinterface

// File: rtl/random_spawner.sv
// Pseudo-random obstacle generator: each slow-tick edge advances a 16-bit Galois LFSR
// and offers a (lane, gap) descriptor; spawns arriving while the consumer is busy are counted.
module random_spawner #(
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter logic [15:0] TAPS    = 16'hB400,
    parameter int unsigned LANES   = 3,
    parameter logic [3:0]  GAP_MIN = 4'd2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick_in,
    input  logic                  enable,
    random_spawner_if.master      spawn,
    output logic [7:0]            drop_cnt,
    output logic [15:0]           lfsr_q
);

    // An all-zero seed would park the LFSR forever, so it is swapped for 1.
    localparam logic [15:0] SEED_SAFE = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [2:0]  LANES_W   = 3'(LANES);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic        tick_q;
    logic [15:0] lfsr_d;
    logic [1:0]  lane_q, lane_d;
    logic [3:0]  gap_q, gap_d;
    logic [7:0]  drop_q, drop_d;

    logic        step;
    logic [15:0] lfsr_shift;
    logic [15:0] lfsr_n;
    logic [2:0]  lane_raw;
    logic [2:0]  lane_fold;
    logic [3:0]  gap_raw;
    logic [1:0]  lane_new;
    logic [3:0]  gap_new;

    // Both edges of the divider output are events.
    assign step       = (tick_in ^ tick_q) & enable;

    assign lfsr_shift = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
    assign lfsr_n     = (lfsr_shift == 16'h0000) ? SEED_SAFE : lfsr_shift;

    assign lane_raw   = {1'b0, lfsr_n[1:0]};
    assign lane_fold  = (lane_raw >= LANES_W) ? (lane_raw - LANES_W) : lane_raw;
    assign lane_new   = lane_fold[1:0];
    assign gap_raw    = lfsr_n[7:4];
    assign gap_new    = (gap_raw < GAP_MIN) ? GAP_MIN : gap_raw;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        gap_d   = gap_q;
        drop_d  = drop_q;
        lfsr_d  = step ? lfsr_n : lfsr_q;

        unique case (state_q)
            EMPTY: begin
                if (step) begin
                    lane_d  = lane_new;
                    gap_d   = gap_new;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (spawn.spawn_ready) begin
                    // A coinciding step refills the slot in the same edge the old one leaves.
                    if (step) begin
                        lane_d = lane_new;
                        gap_d  = gap_new;
                    end else begin
                        state_d = EMPTY;
                    end
                end else if (step && (drop_q != 8'hFF)) begin
                    drop_d = drop_q + 8'd1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            tick_q  <= 1'b0;
            lfsr_q  <= SEED_SAFE;
            lane_q  <= 2'd0;
            gap_q   <= 4'd0;
            drop_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_in;
            lfsr_q  <= lfsr_d;
            lane_q  <= lane_d;
            gap_q   <= gap_d;
            drop_q  <= drop_d;
        end
    end

    assign spawn.spawn_valid = (state_q == FULL);
    assign spawn.spawn_lane  = lane_q;
    assign spawn.spawn_gap   = gap_q;
    assign drop_cnt          = drop_q;

endmodule
